afe_pulse_capture: RTL and testbench
====================================

# afe_pulse_capture

Receive-side counterpart of the AFE pulser output: decodes the 8-bit-per-cycle deserialized stream of a fast discriminator/pulser line into the timing of a single pulse. Once armed, it locates the first rising edge at fast-bit resolution, measures the pulse's high time across any number of words, and reports one result with a single-cycle `valid` strobe. It sits in the divided-clock domain directly after the input ISERDES and feeds pulser loop-back self-test and AFE timing calibration logic.

## Interface
Parameters:
- none; all widths are fixed as listed below.

Ports:
- `clk`  in  1  divided (word) clock; one deserialized word per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  deserialized word; bit 0 is earliest in time, bit 7 is latest.
- `y0`  in  1  idle level of the line; `din` is inverted when `y0`=1.
- `arm`  in  1  single-cycle request to capture the next pulse.
- `armed`  out  1  capture in progress (WAIT_RISE or HIGH).
- `valid`  out  1  one-cycle strobe; result outputs are updated in the same cycle.
- `width`  out  16  pulse high time in fast bits; saturates at 16'hffff.
- `rise_pos`  out  3  bit index of the rising edge within its word.
- `rise_word`  out  16  number of words examined before the word containing the rising edge; saturates.
- `overflow`  out  1  set when `width` saturated in the reported result.

## Operation
- Normalized word: `w = din ^ {8{y0}}`. A 1 bit means active. A rise is a 0→1 transition between consecutive bits. The bit preceding `w[0]` is `prev`, the registered `w[7]` of the previous cycle.
- States:
  - IDLE: waiting for `arm`.
  - WAIT_RISE: searching for the first rise.
  - HIGH: pulse in progress across word boundaries.
- IDLE, `arm`=1: go to WAIT_RISE; clear `width`/`rise_word` accumulators; set `prev`=1. This forces a pulse that is already high at arm time to be ignored until the line returns low.
- WAIT_RISE: find the lowest p where `w[p]`=1 and the preceding bit is 0.
  - No rise in the word: increment `rise_word` (saturating at 16'hffff) and stay in WAIT_RISE.
  - Rise found: latch p and look for the lowest q>p with `w[q]`=0.
  - Fall q found in the same word: width=q−p; emit the result; go to IDLE.
  - No fall in the word: accumulate 8−p; go to HIGH.
- HIGH:
  - `w`=8'hff: width += 8, saturating at 16'hffff and setting the overflow flag.
  - Otherwise: width += q, where q is the lowest 0 bit; emit the result; go to IDLE.
- Only the first pulse after arm is reported. Later rises in the same or following words are ignored until the next `arm`.
- `arm` while in WAIT_RISE or HIGH restarts the capture exactly as from IDLE. No result is emitted for the aborted pulse.
- `y0` is static during a capture. A change mid-capture gives undefined results but must not hang the FSM; the next `arm` recovers it.
- Arithmetic: the accumulator is 16 bits and saturating. Once saturated, it stays at 16'hffff until the fall. `overflow` is reported with the result.

## Timing
- Reset (`rst_n`=0, async): state IDLE, `prev`=1. Outputs reset values:
  - `armed`=0, `valid`=0, `width`=0, `rise_pos`=0, `rise_word`=0, `overflow`=0.
  - Reset mid-capture discards the capture; no `valid` is emitted.
- `arm` sampled high in cycle N: `armed`=1 from cycle N+1. `din` in cycle N+1 is the first word examined (`rise_word` 0).
- Word containing the fall presented in cycle k: in cycle k+1, `valid`=1, result outputs are updated, and `armed`=0.
- `arm` coincident with the falling-edge word: the arm wins. No `valid` is emitted and capture restarts.
- Results hold until the next `valid`. `valid` is never high for two consecutive cycles.
- Minimum re-arm: `arm` in the same cycle as `valid` is accepted.

## Test plan
- `y0`=0, arm, then `din` 00, 3C, 00 → valid one cycle after 3C; `rise_pos`=2, `width`=4, `rise_word`=1, `overflow`=0.
- Multi-word pulse, `din` F0, FF, FF, 07 → `rise_pos`=4, `width`=4+8+8+3=23, `rise_word`=0; valid one cycle after 07.
- Already high at arm, `din` FF, FF, 00, 01, 00 → first pulse ignored; `rise_pos`=0, `width`=1, `rise_word`=3. Also: `din` 66 → `rise_pos`=1, `width`=2, and the second pulse is ignored.
- `y0`=1, `din` FF, C3 → same result as normalized 00, 3C (`width`=4, `rise_pos`=2). Also: `arm` pulsed mid-HIGH → no valid for the aborted pulse; the next pulse is reported correctly.
- Saturation: rise at bit 0, then 8200 words of FF, then 00 → `width`=16'hffff, `overflow`=1, single valid.
- Assert `rst_n`=0 during HIGH → all outputs 0 immediately, no valid. After release, arm and a 3C pulse → normal result.

Source files
------------

// File: rtl/afe_pulse_capture.sv
// afe_pulse_capture: locates the first pulse after arm in an 8-bit-per-word
// deserialized stream and reports rise position, word offset and high time.
module afe_pulse_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        y0,
  input  logic        arm,
  output logic        armed,
  output logic        valid,
  output logic [15:0] width,
  output logic [2:0]  rise_pos,
  output logic [15:0] rise_word,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  w, pre, rise_vec;
  logic        prev;
  logic        rise_found, fall_found, zero_found, emit, sat;
  logic [2:0]  rise_p;
  logic [3:0]  fall_q, zero_q, add_val;
  logic [16:0] sum;
  logic [15:0] width_nxt;
  logic        ovf_nxt;
  logic [15:0] acc_w, acc_rw;
  logic [2:0]  acc_pos;
  logic        acc_ovf;

  // Normalize so that 1 always means "active"; pre[i] is the bit just before w[i].
  assign w        = din ^ {8{y0}};
  assign pre      = {w[6:0], prev};
  assign rise_vec = w & ~pre;

  // Bit scans: lowest rise, lowest fall above it, lowest zero of the word.
  always_comb begin
    rise_found = 1'b0;
    rise_p     = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (rise_vec[i]) begin
        rise_found = 1'b1;
        rise_p     = 3'(i);
      end
    fall_found = 1'b0;
    fall_q     = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (!w[i] && (i > int'(rise_p))) begin
        fall_found = 1'b1;
        fall_q     = 4'(i);
      end
    zero_found = 1'b0;
    zero_q     = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (!w[i]) begin
        zero_found = 1'b1;
        zero_q     = 4'(i);
      end
  end

  // Width contribution of this word and the saturating accumulated result.
  always_comb begin
    add_val = 4'd0;
    if (state == WAIT_RISE)
      add_val = fall_found ? (fall_q - {1'b0, rise_p}) : (4'd8 - {1'b0, rise_p});
    else if (state == HIGH)
      add_val = zero_found ? zero_q : 4'd8;
    sum       = {1'b0, acc_w} + {13'd0, add_val};
    sat       = sum[16];
    width_nxt = sat ? 16'hffff : sum[15:0];
    ovf_nxt   = acc_ovf | sat;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; arm overrides everything, including a fall in the same word.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      WAIT_RISE:
        if (rise_found) begin
          if (fall_found) begin
            emit      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HIGH;
          end
        end
      HIGH:
        if (zero_found) begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end
      default: ;
    endcase
    if (arm) begin
      state_nxt = WAIT_RISE;
      emit      = 1'b0;
    end
  end

  // FSM outputs.
  always_comb begin
    armed = (state != IDLE);
  end

  // Accumulators, edge history and the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= 1'b1;
      acc_w     <= '0;
      acc_rw    <= '0;
      acc_pos   <= '0;
      acc_ovf   <= 1'b0;
      valid     <= 1'b0;
      width     <= '0;
      rise_pos  <= '0;
      rise_word <= '0;
      overflow  <= 1'b0;
    end else begin
      valid <= emit;
      // A forced 1 makes a line already high at arm time look like no rise.
      prev  <= arm ? 1'b1 : w[7];
      if (arm) begin
        acc_w   <= '0;
        acc_rw  <= '0;
        acc_pos <= '0;
        acc_ovf <= 1'b0;
      end else if (state == WAIT_RISE) begin
        if (rise_found) begin
          acc_pos <= rise_p;
          acc_w   <= width_nxt;
          acc_ovf <= ovf_nxt;
        end else if (acc_rw != 16'hffff) begin
          acc_rw <= acc_rw + 16'd1;
        end
      end else if (state == HIGH) begin
        acc_w   <= width_nxt;
        acc_ovf <= ovf_nxt;
      end
      if (emit) begin
        width     <= width_nxt;
        overflow  <= ovf_nxt;
        rise_pos  <= (state == WAIT_RISE) ? rise_p : acc_pos;
        rise_word <= acc_rw;
      end
    end
  end
endmodule

// File: tb/tb_afe_pulse_capture.sv
// Self-checking bench for afe_pulse_capture: captures are described as word
// lists and checked cycle by cycle against a bit-stream reference model.
module tb_afe_pulse_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        y0 = 1'b0;
  logic        arm = 1'b0;
  logic        armed, valid, overflow;
  logic [15:0] width, rise_word;
  logic [2:0]  rise_pos;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stim[$];
  logic        exp_found;
  int          exp_fw;
  logic [15:0] exp_width, exp_rw;
  logic [2:0]  exp_pos;
  logic        exp_ovf;

  afe_pulse_capture dut (
    .clk(clk), .rst_n(rst_n), .din(din), .y0(y0), .arm(arm),
    .armed(armed), .valid(valid), .width(width), .rise_pos(rise_pos),
    .rise_word(rise_word), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: flatten the words from index s into a time-ordered bit stream
  // preceded by an assumed-high bit, then find first rise and following fall.
  task automatic compute_model(input int s, input logic y);
    int  nb, r, f;
    logic pb, b;
    nb = (stim.size() - s) * 8;
    pb = 1'b1;
    r  = -1;
    f  = -1;
    for (int k = 0; k < nb; k++) begin
      b = stim[s + k / 8][k % 8] ^ y;
      if (r < 0) begin
        if (b && !pb) r = k;
      end else if (f < 0 && !b) begin
        f = k;
      end
      pb = b;
    end
    exp_found = (f >= 0);
    exp_fw    = exp_found ? s + f / 8 : -1;
    exp_width = (f - r > 65535) ? 16'hffff : 16'(f - r);
    exp_ovf   = (f - r > 65535);
    exp_rw    = (r / 8 > 65535) ? 16'hffff : 16'(r / 8);
    exp_pos   = 3'(r % 8);
  endtask

  // Arm, feed stim, optionally re-arm alongside word rearm_at; check every cycle.
  task automatic run_capture(input int rearm_at, input logic y);
    logic exp_v, exp_a;
    y0  = y;
    din = {8{y}};
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_armed: got %b want 1", armed);
    end
    compute_model(rearm_at + 1, y);
    for (int j = 0; j < stim.size(); j++) begin
      din = stim[j];
      arm = (j == rearm_at);
      @(posedge clk); #1;
      arm   = 1'b0;
      exp_v = exp_found && (j == exp_fw);
      exp_a = (j <= rearm_at) || !(exp_found && j >= exp_fw);
      n_checks++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL valid word %0d: got %b want %b", j, valid, exp_v);
      end
      n_checks++;
      if (armed !== exp_a) begin
        n_fail++;
        $display("FAIL armed word %0d: got %b want %b", j, armed, exp_a);
      end
      if (exp_v) begin
        n_checks++;
        if (width !== exp_width || rise_pos !== exp_pos ||
            rise_word !== exp_rw || overflow !== exp_ovf) begin
          n_fail++;
          $display("FAIL result: got w=%h p=%0d rw=%h o=%b want w=%h p=%0d rw=%h o=%b",
                   width, rise_pos, rise_word, overflow,
                   exp_width, exp_pos, exp_rw, exp_ovf);
        end
      end
    end
    din = {8{y}};
  endtask

  task automatic check_zero_outputs(input string tag);
    n_checks++;
    if (armed !== 1'b0 || valid !== 1'b0 || width !== 16'h0 ||
        rise_pos !== 3'd0 || rise_word !== 16'h0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got a=%b v=%b w=%h p=%0d rw=%h o=%b want all 0",
               tag, armed, valid, width, rise_pos, rise_word, overflow);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("after_reset");
  endtask

  task automatic test_basic;
    stim = '{8'h00, 8'h3C, 8'h00};
    run_capture(-1, 1'b0);
    stim = '{8'hF0, 8'hFF, 8'hFF, 8'h07};
    run_capture(-1, 1'b0);
  endtask

  task automatic test_already_high;
    stim = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00};
    run_capture(-1, 1'b0);
    stim = '{8'h66, 8'h00, 8'h3C};
    run_capture(-1, 1'b0);
  endtask

  task automatic test_inverted;
    stim = '{8'hFF, 8'hC3, 8'hFF};
    run_capture(-1, 1'b1);
  endtask

  task automatic test_abort;
    // Re-arm mid-HIGH, then re-arm together with the falling-edge word.
    stim = '{8'hF0, 8'hFF, 8'hFF, 8'h00, 8'h3C, 8'h00};
    run_capture(1, 1'b0);
    stim = '{8'hF0, 8'hFF, 8'h07, 8'h0E, 8'h00};
    run_capture(2, 1'b0);
  endtask

  task automatic test_back_to_back;
    // Each capture ends on its fall word, so the next arm lands on the valid cycle.
    stim = '{8'h00, 8'h18};
    run_capture(-1, 1'b0);
    stim = '{8'h3C};
    run_capture(-1, 1'b0);
    stim = '{8'h80, 8'h01, 8'h00};
    run_capture(-1, 1'b0);
  endtask

  task automatic test_saturation;
    stim = '{8'h00};
    for (int i = 0; i < 8200; i++) stim.push_back(8'hFF);
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    run_capture(-1, 1'b0);
  endtask

  task automatic test_reset_mid;
    y0  = 1'b0;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    din = 8'hF0;
    @(posedge clk); #1;
    din = 8'hFF;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid");
    din = 8'h00;
    @(posedge clk); #1;
    check_zero_outputs("reset_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim = '{8'h00, 8'h3C, 8'h00};
    run_capture(-1, 1'b0);
  endtask

  task automatic test_random;
    logic       y;
    logic [7:0] wv;
    int         n, sel;
    for (int it = 0; it < 30; it++) begin
      y = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      stim.delete();
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: wv = 8'h00;
          1: wv = 8'hFF;
          2: wv = 8'hF0;
          3: wv = 8'h0F;
          default: wv = 8'($urandom);
        endcase
        stim.push_back(wv ^ {8{y}});
      end
      stim.push_back(8'h00 ^ {8{y}});
      stim.push_back(8'h01 ^ {8{y}});
      stim.push_back(8'h00 ^ {8{y}});
      run_capture(-1, y);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_already_high;
    test_inverted;
    test_abort;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
